// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter sharing one 4-bit, six-function ALU.
// Winner's operands are latched; result is registered with a per-requester done pulse.
module alu_share_arbiter (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Req0,
    input  logic       Req1,
    input  logic [3:0] A0,
    input  logic [3:0] B0,
    input  logic [3:0] A1,
    input  logic [3:0] B1,
    input  logic [2:0] F0,
    input  logic [2:0] F1,
    output logic [7:0] Result,
    output logic       Done0,
    output logic       Done1,
    output logic       Grant,
    output logic       Busy,
    output logic [7:0] OpCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [2:0] f_q, f_d;
    logic       grant_q, grant_d;
    logic       ptr_q, ptr_d;
    logic [7:0] result_q, result_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic [7:0] opcount_q, opcount_d;
    logic [7:0] alu_y;
    logic [4:0] sum;
    logic       win;

    assign sum = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        alu_y = 8'h00;
        case (f_q)
            3'b000,
            3'b001:  alu_y = {3'b000, sum};
            3'b010:  alu_y = {{4{b_q[3]}}, b_q};
            3'b011:  alu_y = {7'b0, |{a_q, b_q}};
            3'b100:  alu_y = {7'b0, &{a_q, b_q}};
            3'b101:  alu_y = {a_q, b_q};
            default: alu_y = 8'h00;
        endcase
    end

    // Sole requester wins; on contention the pointer decides.
    assign win = (Req0 & Req1) ? ptr_q : Req1;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        f_d       = f_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        result_d  = result_q;
        opcount_d = opcount_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Req0 | Req1) begin
                    grant_d = win;
                    a_d     = win ? A1 : A0;
                    b_d     = win ? B1 : B0;
                    f_d     = win ? F1 : F0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_y;
                done0_d  = ~grant_q;
                done1_d  = grant_q;
                state_d  = RESP;
            end
            RESP: begin
                opcount_d = opcount_q + 8'd1;
                ptr_d     = ~grant_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            a_q       <= 4'h0;
            b_q       <= 4'h0;
            f_q       <= 3'b000;
            grant_q   <= 1'b0;
            ptr_q     <= 1'b0;
            result_q  <= 8'h00;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            opcount_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            f_q       <= f_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            result_q  <= result_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            opcount_q <= opcount_d;
        end
    end

    assign Result  = result_q;
    assign Done0   = done0_q;
    assign Done1   = done1_q;
    assign Grant   = grant_q;
    assign Busy    = (state_q != IDLE);
    assign OpCount = opcount_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed ops, a per-cycle reference model,
// and literal expectations for the documented scenarios.
module tb_alu_share_arbiter;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Req0 = 1'b0, Req1 = 1'b0;
    logic [3:0] A0 = 4'h0, B0 = 4'h0, A1 = 4'h0, B1 = 4'h0;
    logic [2:0] F0 = 3'b000, F1 = 3'b000;
    logic [7:0] Result, OpCount;
    logic       Done0, Done1, Grant, Busy;

    int errs = 0;
    int checks = 0;

    alu_share_arbiter dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Req0   (Req0),
        .Req1   (Req1),
        .A0     (A0),
        .B0     (B0),
        .A1     (A1),
        .B1     (B1),
        .F0     (F0),
        .F1     (F1),
        .Result (Result),
        .Done0  (Done0),
        .Done1  (Done1),
        .Grant  (Grant),
        .Busy   (Busy),
        .OpCount(OpCount)
    );

    always #5 Clock = ~Clock;

    // Reference ALU written from the function table with plain integers.
    function automatic int alu_ref(int a, int b, int f);
        case (f)
            0, 1:    return a + b;
            2:       return (b >= 8) ? b + 240 : b;
            3:       return (a != 0 || b != 0) ? 1 : 0;
            4:       return (a == 15 && b == 15) ? 1 : 0;
            5:       return a * 16 + b;
            default: return 0;
        endcase
    endfunction

    // Model: cycles remaining in the current operation (0 = idle).
    int m_left = 0, m_res = 0, m_pend = 0, m_grant = 0, m_cnt = 0, m_ptr = 0;
    int m_d0 = 0, m_d1 = 0, w;
    bit started = 0;

    always @(posedge Clock) begin
        if (Reset) begin
            m_left = 0; m_res = 0; m_d0 = 0; m_d1 = 0;
            m_grant = 0; m_cnt = 0; m_ptr = 0;
            started = 1;
        end else if (m_left == 0) begin
            if (Req0 || Req1) begin
                w = (Req0 && Req1) ? m_ptr : (Req1 ? 1 : 0);
                m_grant = w;
                m_pend = (w == 1) ? alu_ref(A1, B1, F1) : alu_ref(A0, B0, F0);
                m_left = 2;
            end
        end else if (m_left == 2) begin
            m_res = m_pend;
            m_d0 = (m_grant == 0) ? 1 : 0;
            m_d1 = (m_grant == 1) ? 1 : 0;
            m_left = 1;
        end else begin
            m_d0 = 0; m_d1 = 0;
            m_cnt = (m_cnt + 1) % 256;
            m_ptr = 1 - m_grant;
            m_left = 0;
        end
        #1;
        if (started) begin
            checks++;
            if (Result !== m_res[7:0] || Done0 !== m_d0[0] || Done1 !== m_d1[0] ||
                Busy !== (m_left != 0) || OpCount !== m_cnt[7:0] ||
                (m_left != 0 && Grant !== m_grant[0])) begin
                errs++;
                $display("FAIL model t=%0t got res=%h d0=%b d1=%b busy=%b cnt=%h gnt=%b exp res=%h d0=%0d d1=%0d busy=%0d cnt=%h gnt=%0d",
                         $time, Result, Done0, Done1, Busy, OpCount, Grant,
                         m_res[7:0], m_d0, m_d1, (m_left != 0), m_cnt[7:0], m_grant);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Issue one request, wait for its Done, check latency and result, release.
    task automatic op(input int r, input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] f, input logic [7:0] exp, input string nm);
        int lat;
        bit seen;
        if (r == 0) begin A0 = a; B0 = b; F0 = f; Req0 = 1'b1; end
        else        begin A1 = a; B1 = b; F1 = f; Req1 = 1'b1; end
        lat = 0;
        seen = 0;
        while (!seen && lat < 10) begin
            @(negedge Clock);
            lat++;
            if ((r == 0 && Done0) || (r == 1 && Done1)) seen = 1;
        end
        chk({nm, "_seen"}, {7'b0, seen}, 8'h01);
        chk({nm, "_latency"}, lat[7:0], 8'd2);
        chk({nm, "_result"}, Result, exp);
        chk({nm, "_grant"}, {7'b0, Grant}, r[7:0]);
        Req0 = 1'b0;
        Req1 = 1'b0;
        tick(1);
    endtask

    initial begin
        int n, prev, c0, c1;
        int who[3];
        int at[3];
        logic [7:0] rs[3];

        tick(2);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("idle_busy", {7'b0, Busy}, 8'h00);
            chk("idle_count", OpCount, 8'h00);
            chk("idle_result", Result, 8'h00);
            chk("idle_done", {6'b0, Done1, Done0}, 8'h00);
        end

        op(0, 4'hF, 4'h1, 3'b000, 8'h10, "add_carry");
        chk("model_pin_add", m_res[7:0], 8'h10);
        chk("count_after_first", OpCount, 8'h01);
        chk("done_low_after", {6'b0, Done1, Done0}, 8'h00);

        // Fresh pointer so contention starts with requester 0.
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        A0 = 4'h3; B0 = 4'h5; F0 = 3'b101;
        A1 = 4'h0; B1 = 4'h9; F1 = 3'b010;
        Req0 = 1'b1;
        Req1 = 1'b1;
        n = 0;
        for (int i = 0; i < 15 && n < 3; i++) begin
            @(negedge Clock);
            if (Done0 || Done1) begin
                who[n] = Done1 ? 1 : 0;
                at[n] = i;
                rs[n] = Result;
                n++;
            end
        end
        Req0 = 1'b0;
        Req1 = 1'b0;
        chk("rr_ops_seen", n[7:0], 8'd3);
        if (n == 3) begin
            chk("rr_who0", who[0][7:0], 8'd0);
            chk("rr_res0", rs[0], 8'h35);
            chk("rr_who1", who[1][7:0], 8'd1);
            chk("rr_res1", rs[1], 8'hF9);
            chk("rr_who2", who[2][7:0], 8'd0);
            chk("rr_res2", rs[2], 8'h35);
            chk("rr_gap01", at[1] - at[0], 8'd3);
            chk("rr_gap12", at[2] - at[1], 8'd3);
        end
        tick(1);
        chk("rr_count", OpCount, 8'd3);

        op(1, 4'h0, 4'h0, 3'b011, 8'h00, "or_reduce_zero");
        op(1, 4'hF, 4'hF, 3'b100, 8'h01, "and_reduce_ones");
        chk("model_pin_and", m_res[7:0], 8'h01);
        op(1, 4'hF, 4'hF, 3'b111, 8'h00, "func_111");
        op(1, 4'hC, 4'h5, 3'b001, 8'h11, "add_001");
        chk("count_before_abort", OpCount, 8'd7);

        A0 = 4'h7; B0 = 4'h7; F0 = 3'b101;
        Req0 = 1'b1;
        tick(1);
        chk("abort_in_exec", {7'b0, Busy}, 8'h01);
        Reset = 1'b1;
        Req0 = 1'b0;
        tick(1);
        chk("abort_done", {6'b0, Done1, Done0}, 8'h00);
        chk("abort_result", Result, 8'h00);
        chk("abort_busy", {7'b0, Busy}, 8'h00);
        chk("abort_count", OpCount, 8'h00);
        Reset = 1'b0;
        c0 = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (Done0 || Done1) c0++;
        end
        chk("abort_no_late_done", c0[7:0], 8'd0);

        A0 = 4'h1; B0 = 4'h2; F0 = 3'b000;
        Req0 = 1'b1;
        n = 0;
        prev = 0;
        c1 = 0;
        for (int i = 0; i < 800 && n < 256; i++) begin
            @(negedge Clock);
            if (Done0) begin
                if (prev != 0) c1++;
                n++;
                if (n == 256) Req0 = 1'b0;
            end
            prev = Done0 ? 1 : 0;
        end
        Req0 = 1'b0;
        chk("wrap_ops_lo", n[7:0], 8'd0);
        chk("wrap_ops_hi", n[15:8], 8'd1);
        chk("wrap_wide_dones", c1[7:0], 8'd0);
        chk("wrap_result", Result, 8'h03);
        tick(1);
        chk("wrap_count", OpCount, 8'h00);
        chk("wrap_done_low", {7'b0, Done0}, 8'h00);
        tick(3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
